// File: rtl/gpio_irq_controller_if.sv
// Register-bus link between the MCU bus decoder (master) and the GPIO controller (slave).
interface gpio_irq_controller_if #(
    parameter int unsigned GPIO_VA_WIDTH = 6,
    parameter int unsigned BUS_ACC_WIDTH = 2,
    parameter int unsigned BUS_WIDTH     = 32
);
    logic [GPIO_VA_WIDTH-1:0] addr;
    logic                     w_rb;
    logic [BUS_ACC_WIDTH-1:0] acc;
    logic [BUS_WIDTH-1:0]     wdata;
    logic                     req;
    logic [BUS_WIDTH-1:0]     rdata;
    logic                     resp;
    logic                     fault;

    modport master (
        output addr, w_rb, acc, wdata, req,
        input  rdata, resp, fault
    );

    modport slave (
        input  addr, w_rb, acc, wdata, req,
        output rdata, resp, fault
    );
endinterface

// File: rtl/gpio_irq_controller.sv
// GPIO with direction control, atomic set/clear/toggle, synchronised inputs,
// per-pin edge detection into sticky pending bits and a registered level interrupt.
module gpio_irq_controller #(
    parameter int unsigned             WIDTH         = 8,
    parameter int unsigned             SYNC_STAGES   = 2,
    parameter int unsigned             GPIO_VA_WIDTH = 6,
    parameter int unsigned             BUS_ACC_WIDTH = 2,
    parameter int unsigned             BUS_WIDTH     = 32,
    parameter logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B   = BUS_ACC_WIDTH'(2),
    parameter bit                      IOR_DIR_IN    = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    output logic [WIDTH-1:0] dir,
    input  logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] o,
    output logic             irq,
    gpio_irq_controller_if.slave bus
);

    localparam logic [GPIO_VA_WIDTH-1:0] ADDR_D    = GPIO_VA_WIDTH'('h00);
    localparam logic [GPIO_VA_WIDTH-1:0] ADDR_DIR  = GPIO_VA_WIDTH'('h04);
    localparam logic [GPIO_VA_WIDTH-1:0] ADDR_SET  = GPIO_VA_WIDTH'('h08);
    localparam logic [GPIO_VA_WIDTH-1:0] ADDR_CLR  = GPIO_VA_WIDTH'('h0C);
    localparam logic [GPIO_VA_WIDTH-1:0] ADDR_TGL  = GPIO_VA_WIDTH'('h10);
    localparam logic [GPIO_VA_WIDTH-1:0] ADDR_IE   = GPIO_VA_WIDTH'('h14);
    localparam logic [GPIO_VA_WIDTH-1:0] ADDR_RISE = GPIO_VA_WIDTH'('h18);
    localparam logic [GPIO_VA_WIDTH-1:0] ADDR_FALL = GPIO_VA_WIDTH'('h1C);
    localparam logic [GPIO_VA_WIDTH-1:0] ADDR_IP   = GPIO_VA_WIDTH'('h20);

    localparam int unsigned REG_D    = 0;
    localparam int unsigned REG_DIR  = 1;
    localparam int unsigned REG_SET  = 2;
    localparam int unsigned REG_CLR  = 3;
    localparam int unsigned REG_TGL  = 4;
    localparam int unsigned REG_IE   = 5;
    localparam int unsigned REG_RISE = 6;
    localparam int unsigned REG_FALL = 7;
    localparam int unsigned REG_IP   = 8;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q, sin;
    logic [WIDTH-1:0] o_q, o_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] ie_q, ie_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] ip_q, ip_d;
    logic [BUS_WIDTH-1:0] rdata_q, rdata_d;
    logic resp_q, irq_q;

    logic [8:0]       sel;
    logic             readable, valid, wr_en, rd_en;
    logic [WIDTH-1:0] wd, w1c, edge_set, rd_val;
    logic             unused_wdata;

    assign sin          = sync_q[SYNC_STAGES-1];
    assign wd           = bus.wdata[WIDTH-1:0];
    assign unused_wdata = ^bus.wdata;

    always_comb begin
        sel = '0;
        unique case (bus.addr)
            ADDR_D:    sel[REG_D]    = 1'b1;
            ADDR_DIR:  sel[REG_DIR]  = 1'b1;
            ADDR_SET:  sel[REG_SET]  = 1'b1;
            ADDR_CLR:  sel[REG_CLR]  = 1'b1;
            ADDR_TGL:  sel[REG_TGL]  = 1'b1;
            ADDR_IE:   sel[REG_IE]   = 1'b1;
            ADDR_RISE: sel[REG_RISE] = 1'b1;
            ADDR_FALL: sel[REG_FALL] = 1'b1;
            ADDR_IP:   sel[REG_IP]   = 1'b1;
            default:   sel = '0;
        endcase
    end

    // SET/CLR/TGL are write-only strobes; reading them is a bus fault.
    assign readable = sel[REG_D] | sel[REG_DIR] | sel[REG_IE] | sel[REG_RISE] | sel[REG_FALL]
                    | sel[REG_IP];
    assign valid    = (bus.acc == BUS_ACC_4B) & (bus.w_rb ? (|sel) : readable);
    assign wr_en    = bus.req & valid & bus.w_rb;
    assign rd_en    = bus.req & valid & ~bus.w_rb;

    assign edge_set = (sin & ~prev_q & rise_q) | (~sin & prev_q & fall_q);
    assign w1c      = (wr_en & sel[REG_IP]) ? wd : '0;

    assign rd_val = ({WIDTH{sel[REG_D]}}    & sin)
                  | ({WIDTH{sel[REG_DIR]}}  & dir_q)
                  | ({WIDTH{sel[REG_IE]}}   & ie_q)
                  | ({WIDTH{sel[REG_RISE]}} & rise_q)
                  | ({WIDTH{sel[REG_FALL]}} & fall_q)
                  | ({WIDTH{sel[REG_IP]}}   & ip_q);

    always_comb begin
        o_d     = o_q;
        dir_d   = dir_q;
        ie_d    = ie_q;
        rise_d  = rise_q;
        fall_d  = fall_q;
        rdata_d = rdata_q;
        if (wr_en) begin
            if (sel[REG_D])    o_d    = wd;
            if (sel[REG_SET])  o_d    = o_q | wd;
            if (sel[REG_CLR])  o_d    = o_q & ~wd;
            if (sel[REG_TGL])  o_d    = o_q ^ wd;
            if (sel[REG_DIR])  dir_d  = wd;
            if (sel[REG_IE])   ie_d   = wd;
            if (sel[REG_RISE]) rise_d = wd;
            if (sel[REG_FALL]) fall_d = wd;
        end
        if (rd_en) rdata_d = BUS_WIDTH'(rd_val);
        // A fresh edge beats a simultaneous write-1-to-clear of the same bit.
        ip_d = edge_set | (ip_q & ~w1c);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q  <= '0;
            prev_q  <= '0;
            o_q     <= '0;
            dir_q   <= '0;
            ie_q    <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            ip_q    <= '0;
            rdata_q <= '0;
            resp_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], i};
            prev_q  <= sin;
            o_q     <= o_d;
            dir_q   <= dir_d;
            ie_q    <= ie_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            ip_q    <= ip_d;
            rdata_q <= rdata_d;
            resp_q  <= bus.req & valid;
            irq_q   <= |(ip_q & ie_q);
        end
    end

    assign dir       = dir_q ^ {WIDTH{IOR_DIR_IN}};
    assign o         = o_q;
    assign irq       = irq_q;
    assign bus.rdata = rdata_q;
    assign bus.resp  = resp_q;
    assign bus.fault = bus.req & ~valid;

endmodule

// File: tb/tb_gpio_irq_controller.sv
// Self-checking bench for gpio_irq_controller: register vector table plus
// hand-written sequences for synchroniser latency, W1C races and reset.
module tb_gpio_irq_controller;

    localparam logic [5:0] A_D = 6'h00, A_DIR = 6'h04, A_SET = 6'h08, A_CLR = 6'h0C;
    localparam logic [5:0] A_TGL = 6'h10, A_IE = 6'h14, A_RISE = 6'h18, A_FALL = 6'h1C;
    localparam logic [5:0] A_IP = 6'h20, A_BAD = 6'h24;
    localparam logic [1:0] ACC4 = 2'd2, ACC1 = 2'd0;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] dir, i, o;
    logic       irq;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rdata = '0;

    gpio_irq_controller_if #(.GPIO_VA_WIDTH(6), .BUS_ACC_WIDTH(2), .BUS_WIDTH(32)) bus ();

    gpio_irq_controller #(
        .WIDTH(8), .SYNC_STAGES(2), .GPIO_VA_WIDTH(6), .BUS_ACC_WIDTH(2), .BUS_WIDTH(32),
        .BUS_ACC_4B(2'd2), .IOR_DIR_IN(1'b1)
    ) dut (
        .clk(clk), .rstn(rstn), .dir(dir), .i(i), .o(o), .irq(irq), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w_rb;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  acc;
        logic        exp_fault;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_o;
        logic [7:0]  exp_dir;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus request; valid reads push their expected data to the scoreboard.
    task automatic op(input logic w, input logic [5:0] a, input logic [31:0] wdat,
                      input logic [1:0] ac, input logic exp_fault, input logic [31:0] exp_rd,
                      input string name);
        logic [31:0] exp;
        @(negedge clk);
        bus.w_rb  = w;
        bus.addr  = a;
        bus.wdata = wdat;
        bus.acc   = ac;
        bus.req   = 1'b1;
        if (!w && !exp_fault) exp_q.push_back(exp_rd);
        #1;
        check({name, " fault"}, {31'b0, bus.fault}, {31'b0, exp_fault});
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        check({name, " resp"}, {31'b0, bus.resp}, {31'b0, !exp_fault});
        if (exp_fault) begin
            check({name, " rdata held"}, bus.rdata, last_rdata);
        end else if (!w) begin
            exp = exp_q.pop_front();
            check({name, " rdata"}, bus.rdata, exp);
            last_rdata = exp;
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input string name);
        op(1'b1, a, d, ACC4, 1'b0, 32'h0, name);
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string name);
        op(1'b0, a, 32'h0, ACC4, 1'b0, exp, name);
    endtask

    initial begin
        //          w_rb  addr    wdata          acc   flt   rdata   o      dir
        vecs.push_back('{1'b0, A_DIR,  32'h0,        ACC4, 1'b0, 32'h00, 8'h00, 8'hFF});
        vecs.push_back('{1'b0, A_D,    32'h0,        ACC4, 1'b0, 32'h00, 8'h00, 8'hFF});
        vecs.push_back('{1'b0, A_IP,   32'h0,        ACC4, 1'b0, 32'h00, 8'h00, 8'hFF});
        vecs.push_back('{1'b1, A_D,    32'hA5,       ACC4, 1'b0, 32'h00, 8'hA5, 8'hFF});
        vecs.push_back('{1'b1, A_SET,  32'h0A,       ACC4, 1'b0, 32'h00, 8'hAF, 8'hFF});
        vecs.push_back('{1'b1, A_CLR,  32'h81,       ACC4, 1'b0, 32'h00, 8'h2E, 8'hFF});
        vecs.push_back('{1'b1, A_TGL,  32'hFF,       ACC4, 1'b0, 32'h00, 8'hD1, 8'hFF});
        vecs.push_back('{1'b1, A_DIR,  32'hFFFF_FF0F, ACC4, 1'b0, 32'h00, 8'hD1, 8'hF0});
        vecs.push_back('{1'b0, A_DIR,  32'h0,        ACC4, 1'b0, 32'h0F, 8'hD1, 8'hF0});
        vecs.push_back('{1'b1, A_IE,   32'h55,       ACC4, 1'b0, 32'h00, 8'hD1, 8'hF0});
        vecs.push_back('{1'b0, A_IE,   32'h0,        ACC4, 1'b0, 32'h55, 8'hD1, 8'hF0});
        vecs.push_back('{1'b1, A_RISE, 32'h33,       ACC4, 1'b0, 32'h00, 8'hD1, 8'hF0});
        vecs.push_back('{1'b0, A_RISE, 32'h0,        ACC4, 1'b0, 32'h33, 8'hD1, 8'hF0});
        vecs.push_back('{1'b1, A_FALL, 32'hCC,       ACC4, 1'b0, 32'h00, 8'hD1, 8'hF0});
        vecs.push_back('{1'b0, A_FALL, 32'h0,        ACC4, 1'b0, 32'hCC, 8'hD1, 8'hF0});
        vecs.push_back('{1'b0, A_SET,  32'h0,        ACC4, 1'b1, 32'h00, 8'hD1, 8'hF0});
        vecs.push_back('{1'b1, A_BAD,  32'hFF,       ACC4, 1'b1, 32'h00, 8'hD1, 8'hF0});
        vecs.push_back('{1'b1, A_D,    32'hFF,       ACC1, 1'b1, 32'h00, 8'hD1, 8'hF0});
        vecs.push_back('{1'b1, A_DIR,  32'h00,       ACC1, 1'b1, 32'h00, 8'hD1, 8'hF0});
        vecs.push_back('{1'b0, A_TGL,  32'h0,        ACC4, 1'b1, 32'h00, 8'hD1, 8'hF0});
        vecs.push_back('{1'b0, A_DIR,  32'h0,        ACC4, 1'b0, 32'h0F, 8'hD1, 8'hF0});
        vecs.push_back('{1'b1, A_IE,   32'h00,       ACC4, 1'b0, 32'h00, 8'hD1, 8'hF0});
        vecs.push_back('{1'b1, A_RISE, 32'h00,       ACC4, 1'b0, 32'h00, 8'hD1, 8'hF0});
        vecs.push_back('{1'b1, A_FALL, 32'h00,       ACC4, 1'b0, 32'h00, 8'hD1, 8'hF0});
        vecs.push_back('{1'b0, A_RISE, 32'h0,        ACC4, 1'b0, 32'h00, 8'hD1, 8'hF0});

        bus.addr = '0; bus.w_rb = 1'b0; bus.acc = ACC4; bus.wdata = '0; bus.req = 1'b0;
        i = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("reset dir", {24'b0, dir}, 32'hFF);
        check("reset o", {24'b0, o}, 32'h0);
        check("reset irq", {31'b0, irq}, 32'h0);
        check("reset resp", {31'b0, bus.resp}, 32'h0);
        check("reset rdata", bus.rdata, 32'h0);

        foreach (vecs[n]) begin
            op(vecs[n].w_rb, vecs[n].addr, vecs[n].wdata, vecs[n].acc, vecs[n].exp_fault,
               vecs[n].exp_rdata, $sformatf("vec%0d", n));
            check($sformatf("vec%0d o", n), {24'b0, o}, {24'b0, vecs[n].exp_o});
            check($sformatf("vec%0d dir", n), {24'b0, dir}, {24'b0, vecs[n].exp_dir});
        end

        // Rising edge on pin 0: IP after 3 edges, irq after 4, then W1C.
        wr(A_RISE, 32'h01, "rise cfg");
        wr(A_IE, 32'h01, "ie cfg");
        @(negedge clk);
        i = 8'h01;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rise irq e2", {31'b0, irq}, 32'h0);
        rd(A_IP, 32'h00, "rise ip e3");
        check("rise irq e3", {31'b0, irq}, 32'h0);
        rd(A_IP, 32'h01, "rise ip e4");
        check("rise irq e4", {31'b0, irq}, 32'h1);
        wr(A_IP, 32'h01, "w1c ip0");
        check("w1c irq same", {31'b0, irq}, 32'h1);
        @(posedge clk);
        #1;
        check("w1c irq next", {31'b0, irq}, 32'h0);
        rd(A_IP, 32'h00, "w1c ip read");

        // Falling edge with IE masked, then unmasked.
        wr(A_IE, 32'h00, "ie off");
        @(negedge clk);
        i = 8'h81;
        repeat (4) @(posedge clk);
        wr(A_FALL, 32'h80, "fall cfg");
        @(negedge clk);
        i = 8'h01;
        repeat (4) @(posedge clk);
        #1;
        check("fall masked irq", {31'b0, irq}, 32'h0);
        rd(A_IP, 32'h80, "fall ip");
        wr(A_IE, 32'h80, "ie 80");
        check("ie write irq same", {31'b0, irq}, 32'h0);
        @(posedge clk);
        #1;
        check("ie write irq next", {31'b0, irq}, 32'h1);

        // W1C racing a new rise on pin 0: the edge wins.
        wr(A_IP, 32'hFF, "clear all");
        @(negedge clk);
        i = 8'h00;
        repeat (4) @(posedge clk);
        rd(A_IP, 32'h00, "ip after fall0");
        @(negedge clk);
        i = 8'h01;
        @(posedge clk);
        @(posedge clk);
        wr(A_IP, 32'h01, "w1c race");
        rd(A_IP, 32'h01, "race ip");
        @(posedge clk);
        #1;
        check("resp one cycle", {31'b0, bus.resp}, 32'h0);

        // Reset during a pending request discards it and clears resp at once.
        wr(A_D, 32'h33, "pre-reset write");
        check("pre-reset o", {24'b0, o}, 32'h33);
        bus.w_rb = 1'b1; bus.addr = A_D; bus.wdata = 32'h44; bus.acc = ACC4; bus.req = 1'b1;
        #1;
        rstn = 1'b0;
        #1;
        check("async resp clr", {31'b0, bus.resp}, 32'h0);
        check("async o clr", {24'b0, o}, 32'h0);
        @(posedge clk);
        #1;
        check("reset req dropped", {24'b0, o}, 32'h0);
        @(negedge clk);
        bus.req = 1'b0;
        rstn = 1'b1;
        last_rdata = '0;
        repeat (4) @(posedge clk);
        #1;
        check("post-reset o", {24'b0, o}, 32'h0);
        check("post-reset dir", {24'b0, dir}, 32'hFF);
        check("post-reset rdata", bus.rdata, 32'h0);
        check("post-reset irq", {31'b0, irq}, 32'h0);

        // Pin 0 stayed high through reset: no pending edge afterwards.
        wr(A_RISE, 32'h01, "held rise cfg");
        wr(A_IE, 32'h01, "held ie cfg");
        repeat (3) @(posedge clk);
        rd(A_IP, 32'h00, "held ip");
        check("held irq", {31'b0, irq}, 32'h0);
        check("scoreboard empty", exp_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
